// File: rtl/vdp_pkg.sv
// ---------------------------------------------------------------------------
// vdp_pkg
// Shared definitions for the background tile renderer.
//   - tile geometry (8x8 tiles, 8bpp pattern rows of 64 bits)
//   - renderer FSM state encoding
//   - pixel_at(): extracts pixel k from a packed pattern row
// ---------------------------------------------------------------------------
package vdp_pkg;

    localparam int TILE_W = 8;
    localparam int TILE_H = 8;
    localparam int PIX_W  = 8;
    localparam int ROW_W  = TILE_W * PIX_W;   // one pattern row, 64 bits

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        DRAW,
        DONE
    } state_t;

    // Pixel k of a row lives in bits [8k+7:8k].
    function automatic logic [PIX_W-1:0] pixel_at(input logic [ROW_W-1:0] row,
                                                  input logic [2:0]       k);
        return row[k*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/tile_row_shifter.sv
// ---------------------------------------------------------------------------
// tile_row_shifter
// Row buffer between the pattern memory and the pixel output. The pattern
// memory's registered output is the "next" row; on i_load (the slot boundary)
// it is swapped into the current-row register, and the pixel for that same
// cycle is taken straight from the incoming row so pixel 0 of every slot is
// emitted without an extra cycle of latency.
// Ports:
//   clk_pix, rst_pix  clock / synchronous active-high reset
//   i_load            slot boundary: capture i_row as the current row
//   i_row             incoming 64-bit pattern row (8 pixels at 8bpp)
//   i_k               pixel index 0..7 within the slot
//   o_pix             selected 8-bit palette index
// ---------------------------------------------------------------------------
module tile_row_shifter
    import vdp_pkg::*;
(
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             i_load,
    input  logic [ROW_W-1:0] i_row,
    input  logic [2:0]       i_k,
    output logic [PIX_W-1:0] o_pix
);

    logic [ROW_W-1:0] r_cur;
    logic [ROW_W-1:0] w_src;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_cur <= '0;
        end else if (i_load) begin
            r_cur <= i_row;
        end
    end

    assign w_src = i_load ? i_row : r_cur;
    assign o_pix = pixel_at(w_src, i_k);

endmodule

// File: rtl/tile_line_renderer.sv
// ---------------------------------------------------------------------------
// tile_line_renderer
// Background tile renderer feeding one bank of the double-buffered line
// buffer. On line_start it latches the line/scroll inputs, then fetches
// tilemap entries and pattern rows in an 8-cycle-per-slot pipeline and
// writes exactly H_RES palette indices to addresses {bank, 0..H_RES-1}.
// Ports:
//   clk_pix, rst_pix            clock / synchronous active-high reset
//   line_start                  one-cycle pulse, render line line_y
//   line_y, scroll_x, scroll_y  line and scroll (latched at line_start)
//   map_addr / map_data         tilemap read {row, col}, data 1 cycle later
//   pat_addr / pat_data         pattern read {tile, fine_y}, data 1 cycle later
//   addr_draw, colour_draw,
//   we_draw                     line buffer write port {bank, x}
//   busy                        high from cycle 1 through the DONE cycle
//   done                        one-cycle pulse after the last write
// ---------------------------------------------------------------------------
module tile_line_renderer
    import vdp_pkg::*;
#(
    parameter int CORDW    = 11,
    parameter int H_RES    = 640,
    parameter int MAP_BITS = 6
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    input  logic                  line_start,
    input  logic [CORDW-1:0]      line_y,
    input  logic [CORDW-1:0]      scroll_x,
    input  logic [CORDW-1:0]      scroll_y,
    output logic [2*MAP_BITS-1:0] map_addr,
    input  logic [7:0]            map_data,
    output logic [10:0]           pat_addr,
    input  logic [ROW_W-1:0]      pat_data,
    output logic [10:0]           addr_draw,
    output logic [7:0]            colour_draw,
    output logic                  we_draw,
    output logic                  busy,
    output logic                  done
);

    localparam logic [10:0] X_END = 11'(H_RES);

    state_t                r_state;
    logic [2:0]            r_ph;       // phase within the 8-cycle slot pipeline
    logic [CORDW-4:0]      r_col;      // column of the next map read
    logic [MAP_BITS-1:0]   r_row;
    logic [2:0]            r_fine_y;
    logic [2:0]            r_fine_x;
    logic                  r_bank;
    logic                  r_slot0;    // still emitting the first (partial) slot
    logic [10:0]           r_x;        // next line buffer address to write

    logic [CORDW-1:0]      w_vy;
    logic [CORDW-4:0]      w_coarse_x;
    logic [2:0]            w_k;
    logic                  w_emit;
    logic                  w_load;
    logic                  w_skip;
    logic [PIX_W-1:0]      w_pix;
    logic                  w_unused_vy;

    assign w_vy        = line_y + scroll_y;
    assign w_coarse_x  = scroll_x[CORDW-1:3];
    assign w_unused_vy = &{1'b0, w_vy[CORDW-1:MAP_BITS+3]};

    // Pattern data for a slot arrives in phase 3, so pixel k is computed in
    // phase (3+k) mod 8 and becomes visible on the outputs one cycle later.
    assign w_k    = r_ph - 3'd3;
    assign w_emit = (r_state == DRAW) || (r_state == PRIME && r_ph == 3'd3);
    assign w_load = w_emit && (r_ph == 3'd3);
    assign w_skip = r_slot0 && (w_k < r_fine_x);

    tile_row_shifter u_shifter (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .i_load  (w_load),
        .i_row   (pat_data),
        .i_k     (w_k),
        .o_pix   (w_pix)
    );

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_state     <= IDLE;
            r_ph        <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_fine_y    <= '0;
            r_fine_x    <= '0;
            r_bank      <= 1'b0;
            r_slot0     <= 1'b0;
            r_x         <= '0;
            map_addr    <= '0;
            pat_addr    <= '0;
            addr_draw   <= '0;
            colour_draw <= '0;
            we_draw     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (line_start) begin
            // A new line always wins, including mid-line: the old line is
            // abandoned silently and the restart timing matches IDLE.
            r_state  <= PRIME;
            r_ph     <= '0;
            r_x      <= '0;
            r_slot0  <= 1'b1;
            r_bank   <= line_y[0];
            r_fine_x <= scroll_x[2:0];
            r_fine_y <= w_vy[2:0];
            r_row    <= w_vy[MAP_BITS+2:3];
            map_addr <= {w_vy[MAP_BITS+2:3], w_coarse_x[MAP_BITS-1:0]};
            r_col    <= w_coarse_x + 1'b1;
            we_draw  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (r_state)
                PRIME, DRAW: begin
                    r_ph    <= r_ph + 3'd1;
                    we_draw <= 1'b0;
                    if (r_state == DRAW && r_x == X_END) begin
                        // Line complete: in-flight fetches are simply dropped.
                        r_state <= DONE;
                        done    <= 1'b1;
                    end else begin
                        if (r_ph == 3'd1) begin
                            pat_addr <= {map_data, r_fine_y};
                        end
                        if (r_ph == 3'd7) begin
                            map_addr <= {r_row, r_col[MAP_BITS-1:0]};
                            r_col    <= r_col + 1'b1;
                        end
                        if (r_ph == 3'd3) begin
                            r_state <= DRAW;
                        end
                        // Phase 2 computes pixel 7, the last one of a slot.
                        if (r_state == DRAW && r_ph == 3'd2) begin
                            r_slot0 <= 1'b0;
                        end
                        if (w_emit && !w_skip) begin
                            we_draw     <= 1'b1;
                            colour_draw <= w_pix;
                            addr_draw   <= {r_bank, r_x[9:0]};
                            r_x         <= r_x + 11'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_line_renderer.sv
// ---------------------------------------------------------------------------
// tb_tile_line_renderer
// Directed bench: identity tilemap (entry = column) and pattern memory whose
// pixel k of tile t is (t*8+k) mod 256, both with one cycle of read latency.
// Cycle 0 is the line_start cycle; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tile_line_renderer;

    localparam int CORDW = 11;
    localparam int H_RES = 640;

    logic              clk_pix = 1'b0;
    logic              rst_pix;
    logic              line_start;
    logic [CORDW-1:0]  line_y, scroll_x, scroll_y;
    logic [11:0]       map_addr;
    logic [7:0]        map_data;
    logic [10:0]       pat_addr;
    logic [63:0]       pat_data;
    logic [10:0]       addr_draw;
    logic [7:0]        colour_draw;
    logic              we_draw, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_pix = ~clk_pix;

    tile_line_renderer dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .line_start  (line_start),
        .line_y      (line_y),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .map_addr    (map_addr),
        .map_data    (map_data),
        .pat_addr    (pat_addr),
        .pat_data    (pat_data),
        .addr_draw   (addr_draw),
        .colour_draw (colour_draw),
        .we_draw     (we_draw),
        .busy        (busy),
        .done        (done)
    );

    // Memory models: identity map, pixel = {tile[4:0], k}.
    always @(posedge clk_pix) begin
        map_data <= {2'b00, map_addr[5:0]};
        for (int k = 0; k < 8; k++) begin
            pat_data[8*k +: 8] <= {pat_addr[7:3], 3'(k)};
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_colour(input int x, input int sx);
        int fx = sx % 8;
        int cx = (sx / 8) % 64;
        int n  = (x + fx) / 8;
        int k  = (x + fx) % 8;
        return ((((cx + n) % 64) * 8) + k) % 256;
    endfunction

    // Called at a falling edge; that cycle becomes cycle 0. Returns in cycle 1
    // with the inputs scrambled to prove they were latched.
    task automatic start_line(input int ly, input int sx, input int sy);
        line_y     = CORDW'(ly);
        scroll_x   = CORDW'(sx);
        scroll_y   = CORDW'(sy);
        line_start = 1'b1;
        @(negedge clk_pix);
        line_start = 1'b0;
        line_y     = ~line_y;
        scroll_x   = ~scroll_x;
        scroll_y   = ~scroll_y;
    endtask

    // Starts in cycle 1 of a line and follows it to done plus one cycle.
    task automatic observe_line(input string name, input int sx, input int bank,
                                input int exp_first, input int exp_done,
                                output int map_c1, output int map_c9,
                                output int pat_c3);
        int c     = 1;
        int nwr   = 0;
        int first = -1;
        bit seen  = 1'b0;
        map_c1 = -1;
        map_c9 = -1;
        pat_c3 = -1;
        check({name, " busy cycle1"}, int'(busy), 1);
        while (!seen && c < 1200) begin
            if (c == 1) map_c1 = int'(map_addr);
            if (c == 9) map_c9 = int'(map_addr);
            if (c == 3) pat_c3 = int'(pat_addr);
            if (we_draw) begin
                if (nwr == 0) first = c;
                check({name, " addr"}, int'(addr_draw), bank * 1024 + nwr);
                check({name, " colour"}, int'(colour_draw), exp_colour(nwr, sx));
                nwr++;
            end
            if (done) begin
                seen = 1'b1;
                check({name, " done cycle"}, c, exp_done);
                check({name, " busy at done"}, int'(busy), 1);
            end else begin
                c++;
                @(negedge clk_pix);
            end
        end
        check({name, " done seen"}, int'(seen), 1);
        check({name, " first write cycle"}, first, exp_first);
        check({name, " write count"}, nwr, H_RES);
        @(negedge clk_pix);
        check({name, " busy after done"}, int'(busy), 0);
        check({name, " done width"}, int'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m1, m9, p3, nd, nw;
        rst_pix    = 1'b1;
        line_start = 1'b0;
        line_y     = '0;
        scroll_x   = '0;
        scroll_y   = '0;
        repeat (3) @(negedge clk_pix);
        check("reset we_draw", int'(we_draw), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset map_addr", int'(map_addr), 0);
        check("reset pat_addr", int'(pat_addr), 0);
        check("reset addr_draw", int'(addr_draw), 0);
        check("reset colour", int'(colour_draw), 0);
        rst_pix = 1'b0;
        @(negedge clk_pix);

        // Identity map, no scroll.
        start_line(0, 0, 0);
        observe_line("identity", 0, 0, 5, 645, m1, m9, p3);
        check("identity map c1", m1, 0);
        check("identity map c9", m9, 1);

        // Fine horizontal scroll of 3 pixels.
        start_line(0, 3, 0);
        observe_line("finex3", 3, 0, 8, 648, m1, m9, p3);

        // Horizontal wrap: coarse 63 then column 0.
        start_line(0, 504, 0);
        observe_line("hwrap", 504, 0, 5, 645, m1, m9, p3);
        check("hwrap slot0 col", m1 % 64, 63);
        check("hwrap slot1 col", m9 % 64, 0);

        // Vertical wrap of vy=512 to row 0, odd bank.
        start_line(1, 0, 511);
        observe_line("vwrap", 0, 1, 5, 645, m1, m9, p3);
        check("vwrap map row", m1 / 64, 0);
        check("vwrap fine_y", p3 % 8, 0);

        // vy=21: row 2, fine_y 5.
        start_line(21, 0, 0);
        observe_line("vrow", 0, 1, 5, 645, m1, m9, p3);
        check("vrow map row", m1 / 64, 2);
        check("vrow fine_y", p3 % 8, 5);
        check("vrow pat tile", p3 / 8, 0);

        // Restart at cycle 100: no done for the aborted line.
        start_line(0, 0, 0);
        nd = 0;
        for (int c = 1; c < 100; c++) begin
            if (done) nd++;
            if (c == 99) check("abort writing before restart", int'(we_draw), 1);
            @(negedge clk_pix);
        end
        start_line(3, 0, 0);
        check("abort no done", nd, 0);
        observe_line("restart", 0, 1, 5, 645, m1, m9, p3);

        // Reset in the middle of DRAW.
        start_line(0, 0, 0);
        repeat (20) @(negedge clk_pix);
        check("pre-reset writing", int'(we_draw), 1);
        rst_pix = 1'b1;
        @(negedge clk_pix);
        check("midreset we_draw", int'(we_draw), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        rst_pix = 1'b0;
        nw = 0;
        repeat (40) begin
            @(negedge clk_pix);
            if (we_draw || busy || done) nw++;
        end
        check("post-reset idle", nw, 0);

        start_line(0, 0, 0);
        observe_line("after reset", 0, 0, 5, 645, m1, m9, p3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
